// File: rtl/onehot_rr_arbiter.sv
// Registered round-robin arbiter with a one-hot grant and an optional hold timeout.
// Every change of owner passes through one all-zero gap cycle.
module onehot_rr_arbiter #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rel,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic         timeout
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;
    localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] ptr, ptr_n;
    logic [PW-1:0] win, win_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  gnt_n;
    logic          timeout_n;

    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;

    // Rotating priority search starting at ptr and wrapping at N-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        win_n     = win;
        cnt_n     = cnt;
        gnt_n     = gnt;
        timeout_n = 1'b0;

        case (state)
            IDLE, GAP: begin
                if (found) begin
                    state_n = GRANT;
                    win_n   = pick;
                    ptr_n   = (pick == LAST_IDX) ? '0 : pick + 1'b1;
                    cnt_n   = '0;
                    gnt_n   = ONE_HOT0 << pick;
                end else begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
            end

            GRANT: begin
                // A release beats the terminal count, so timeout stays low then.
                if (rel || !req[win]) begin
                    state_n = GAP;
                    gnt_n   = '0;
                end else if (HOLD_MAX != 0 && cnt == CNT_LAST) begin
                    state_n   = GAP;
                    gnt_n     = '0;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            win       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            win       <= win_n;
            cnt       <= cnt_n;
            gnt       <= gnt_n;
            gnt_valid <= |gnt_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed bench for onehot_rr_arbiter: one instance with HOLD_MAX=15, one with HOLD_MAX=4,
// both driven by the same req/rel/rst_n.
module tb_onehot_rr_arbiter;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rel;
    logic [N-1:0] req;
    logic [N-1:0] gnt, gnt4;
    logic         gnt_valid, gnt_valid4;
    logic         timeout, timeout4;

    int checks = 0;
    int errors = 0;

    onehot_rr_arbiter #(.N(N), .HOLD_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .gnt(gnt), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    onehot_rr_arbiter #(.N(N), .HOLD_MAX(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
        .gnt(gnt4), .gnt_valid(gnt_valid4), .timeout(timeout4)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        rel   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (gnt !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_gnt edge %0d: got %h want 00", i, gnt);
            end
            checks++;
            if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_flags edge %0d: got valid=%b timeout=%b want 0 0", i, gnt_valid, timeout);
            end
            checks++;
            if (gnt4 !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_gnt4 edge %0d: got %h want 00", i, gnt4);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h01 || gnt_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release: got gnt=%h valid=%b want 01 1", gnt, gnt_valid);
        end
    endtask

    task automatic test_two_requesters();
        logic [7:0] exp_gnt [6] = '{8'h01, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
        logic       rel_seq [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        req = 8'h81;
        for (int i = 0; i < 6; i++) begin
            rel = rel_seq[i];
            tick();
            checks++;
            if (gnt !== exp_gnt[i] || gnt_valid !== (exp_gnt[i] != 8'h00)) begin
                errors++;
                $display("[TB] FAIL two_req step %0d: got gnt=%h valid=%b want %h %b", i, gnt, gnt_valid, exp_gnt[i], exp_gnt[i] != 8'h00);
            end
            checks++;
            if (timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL two_req_timeout step %0d: got %b want 0", i, timeout);
            end
        end
        rel = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_gnt [5] = '{8'h40, 8'h00, 8'h80, 8'h00, 8'h40};
        logic       rel_seq [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        req = 8'hC0;
        for (int i = 0; i < 5; i++) begin
            rel = rel_seq[i];
            tick();
            checks++;
            if (gnt !== exp_gnt[i] || gnt_valid !== (exp_gnt[i] != 8'h00)) begin
                errors++;
                $display("[TB] FAIL wrap step %0d: got gnt=%h valid=%b want %h %b", i, gnt, gnt_valid, exp_gnt[i], exp_gnt[i] != 8'h00);
            end
        end
        rel = 1'b0;
    endtask

    task automatic test_timeout4();
        logic [7:0] exp_gnt [6] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h04};
        logic       exp_to  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        req = 8'h04;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (gnt4 !== exp_gnt[i] || gnt_valid4 !== (exp_gnt[i] != 8'h00)) begin
                errors++;
                $display("[TB] FAIL timeout4_gnt step %0d: got gnt=%h valid=%b want %h %b", i, gnt4, gnt_valid4, exp_gnt[i], exp_gnt[i] != 8'h00);
            end
            checks++;
            if (timeout4 !== exp_to[i]) begin
                errors++;
                $display("[TB] FAIL timeout4_pulse step %0d: got %b want %b", i, timeout4, exp_to[i]);
            end
            checks++;
            if (gnt !== 8'h04) begin
                errors++;
                $display("[TB] FAIL hold15_early step %0d: got %h want 04", i, gnt);
            end
        end
        req = '0;
    endtask

    task automatic test_timeout15();
        logic [7:0] exp_gnt;
        logic       exp_to;
        do_reset();
        req = 8'h04;
        for (int step = 1; step <= 17; step++) begin
            tick();
            exp_gnt = (step == 16) ? 8'h00 : 8'h04;
            exp_to  = (step == 16);
            checks++;
            if (gnt !== exp_gnt || timeout !== exp_to) begin
                errors++;
                $display("[TB] FAIL timeout15 step %0d: got gnt=%h timeout=%b want %h %b", step, gnt, timeout, exp_gnt, exp_to);
            end
        end
        req = '0;
    endtask

    task automatic test_release_beats_timeout();
        do_reset();
        req = 8'h04;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt4 !== 8'h04) begin
                errors++;
                $display("[TB] FAIL rel_vs_to_hold step %0d: got %h want 04", i, gnt4);
            end
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        checks++;
        if (gnt4 !== 8'h00 || timeout4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rel_vs_to_gap: got gnt=%h timeout=%b want 00 0", gnt4, timeout4);
        end
        tick();
        checks++;
        if (gnt4 !== 8'h04 || timeout4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rel_vs_to_regrant: got gnt=%h timeout=%b want 04 0", gnt4, timeout4);
        end
        req = '0;
    endtask

    task automatic test_drop_and_reset();
        logic [7:0] exp_gnt [5] = '{8'h08, 8'h08, 8'h00, 8'h00, 8'h08};
        logic [7:0] req_seq [5] = '{8'h08, 8'h08, 8'h00, 8'h00, 8'h08};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req = req_seq[i];
            tick();
            checks++;
            if (gnt !== exp_gnt[i] || timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL drop step %0d: got gnt=%h timeout=%b want %h 0", i, gnt, timeout, exp_gnt[i]);
            end
        end
        rst_n = 1'b0;
        req   = 8'h08;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midgrant_reset: got gnt=%h valid=%b want 00 0", gnt, gnt_valid);
        end
        req = 8'h88;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h08) begin
            errors++;
            $display("[TB] FAIL ptr_after_reset: got %h want 08", gnt);
        end
        req = '0;
    endtask

    task automatic test_no_preempt();
        do_reset();
        req = 8'h02;
        tick();
        req = 8'h03;
        rel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 8'h02) begin
                errors++;
                $display("[TB] FAIL no_preempt step %0d: got %h want 02", i, gnt);
            end
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        checks++;
        if (gnt !== 8'h01) begin
            errors++;
            $display("[TB] FAIL after_preempt: got %h want 01", gnt);
        end
        req = '0;
        rel = 1'b1;
        tick();
        tick();
        rel = 1'b0;
        req = 8'h10;
        tick();
        checks++;
        if (gnt !== 8'h10) begin
            errors++;
            $display("[TB] FAIL rel_idle_ignored: got %h want 10", gnt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        test_reset();
        test_two_requesters();
        test_wrap();
        test_timeout4();
        test_timeout15();
        test_release_beats_timeout();
        test_drop_and_reset();
        test_no_preempt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
